// File: rtl/banked_regfile_pkg.sv
// Shared mode encodings, bank base addresses and SPSR selection helpers.
// Pure definitions, no state.
// Imported by the address map and the register file top.
package banked_regfile_pkg;

  // Processor mode encodings (CPSR[4:0])
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  // Physical base address of each banked group
  localparam logic [4:0] BASE_FIQ = 5'h10;  // R8..R14
  localparam logic [4:0] BASE_SVC = 5'h17;  // R13, R14
  localparam logic [4:0] BASE_ABT = 5'h19;
  localparam logic [4:0] BASE_IRQ = 5'h1B;
  localparam logic [4:0] BASE_UND = 5'h1D;

  localparam int         NUM_PREGS = 31;
  localparam int         NUM_SPSR  = 5;
  localparam logic [3:0] REG_PC    = 4'd15;

  typedef enum logic [2:0] {
    SPSR_FIQ  = 3'd0,
    SPSR_SVC  = 3'd1,
    SPSR_ABT  = 3'd2,
    SPSR_IRQ  = 3'd3,
    SPSR_UND  = 3'd4,
    SPSR_NONE = 3'd5
  } spsr_sel_e;

  // Which SPSR a mode owns; USR/SYS/unlisted own none
  function automatic spsr_sel_e spsr_sel(input logic [4:0] m);
    case (m)
      MODE_FIQ: spsr_sel = SPSR_FIQ;
      MODE_SVC: spsr_sel = SPSR_SVC;
      MODE_ABT: spsr_sel = SPSR_ABT;
      MODE_IRQ: spsr_sel = SPSR_IRQ;
      MODE_UND: spsr_sel = SPSR_UND;
      default:  spsr_sel = SPSR_NONE;
    endcase
  endfunction

  function automatic logic mode_valid(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: mode_valid = 1'b1;
      default:                      mode_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bank_addr_map.sv
// Logical register + mode -> 5-bit physical register address.
// Purely combinational, zero latency.
// No flow control; user_bank forces the USR view.
import banked_regfile_pkg::*;

module bank_addr_map (
  input  logic [3:0] reg_idx,
  input  logic [4:0] mode,
  input  logic       user_bank,
  output logic [4:0] addr
);

  // Default is the flat USR mapping; banked modes override their high registers
  always_comb begin
    addr = {1'b0, reg_idx};
    if (!user_bank) begin
      case (mode)
        MODE_FIQ: if (reg_idx >= 4'd8 && reg_idx != REG_PC)
                    addr = BASE_FIQ + {1'b0, reg_idx - 4'd8};
        MODE_SVC: if (reg_idx == 4'd13) addr = BASE_SVC;
                  else if (reg_idx == 4'd14) addr = BASE_SVC + 5'd1;
        MODE_ABT: if (reg_idx == 4'd13) addr = BASE_ABT;
                  else if (reg_idx == 4'd14) addr = BASE_ABT + 5'd1;
        MODE_IRQ: if (reg_idx == 4'd13) addr = BASE_IRQ;
                  else if (reg_idx == 4'd14) addr = BASE_IRQ + 5'd1;
        MODE_UND: if (reg_idx == 4'd13) addr = BASE_UND;
                  else if (reg_idx == 4'd14) addr = BASE_UND + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/banked_regfile.sv
// Mode-banked register file: NRD read ports, one write port, SPSR bank.
// Reads and SPSR readout registered, 1-cycle latency with write-through bypass.
// No backpressure; accepts a write and all reads every cycle.
import banked_regfile_pkg::*;

module banked_regfile #(
  parameter int NRD = 3,
  parameter int DW  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_we,
  input  logic [4:0]       mode_in,
  output logic [4:0]       mode,
  input  logic             user_bank,
  input  logic [NRD*4-1:0] rd_reg,
  output logic [NRD*DW-1:0] rd_data,
  input  logic [DW-1:0]    pc_in,
  input  logic             wr_en,
  input  logic [3:0]       wr_reg,
  input  logic [DW-1:0]    wr_data,
  input  logic             spsr_we,
  input  logic [DW-1:0]    spsr_wdata,
  output logic [DW-1:0]    spsr_rdata,
  output logic             mode_err
);

  logic [4:0]        mode_q;
  logic [DW-1:0]     rf_q [NUM_PREGS];
  logic [DW-1:0]     spsr_q [NUM_SPSR];
  logic [NRD*DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0]     spsr_rdata_q, spsr_rdata_d;
  logic              mode_err_q;

  logic [4:0]        wr_addr;
  logic [4:0]        rd_addr [NRD];
  logic              wr_hit;
  spsr_sel_e         cur_spsr;
  logic              spsr_hit;

  // All mapping uses the registered mode, so a same-cycle mode_we only affects later cycles
  bank_addr_map u_wr_map (
    .reg_idx   (wr_reg),
    .mode      (mode_q),
    .user_bank (user_bank),
    .addr      (wr_addr)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd_map
    bank_addr_map u_rd_map (
      .reg_idx   (rd_reg[4*g +: 4]),
      .mode      (mode_q),
      .user_bank (user_bank),
      .addr      (rd_addr[g])
    );
  end

  assign wr_hit   = wr_en && (wr_reg != REG_PC);
  assign cur_spsr = spsr_sel(mode_q);
  assign spsr_hit = spsr_we && (cur_spsr != SPSR_NONE);

  // Next read data: PC for R15, bypass a same-address write, otherwise storage
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_reg[4*i +: 4] == REG_PC)
        rd_data_d[i*DW +: DW] = pc_in;
      else if (wr_hit && (wr_addr == rd_addr[i]))
        rd_data_d[i*DW +: DW] = wr_data;
      else
        rd_data_d[i*DW +: DW] = rf_q[rd_addr[i]];
    end
  end

  // Next SPSR readout: zero in modes without an SPSR, bypass a same-cycle write
  always_comb begin
    spsr_rdata_d = '0;
    if (cur_spsr != SPSR_NONE) begin
      if (spsr_we) spsr_rdata_d = spsr_wdata;
      else         spsr_rdata_d = spsr_q[cur_spsr];
    end
  end

  // Register file, SPSR bank, mode and registered outputs; reset wins over every write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) rf_q[i] <= '0;
      for (int i = 0; i < NUM_SPSR; i++)  spsr_q[i] <= '0;
      mode_q       <= MODE_SVC;
      rd_data_q    <= '0;
      spsr_rdata_q <= '0;
      mode_err_q   <= 1'b0;
    end else begin
      if (wr_hit)   rf_q[wr_addr]    <= wr_data;
      if (spsr_hit) spsr_q[cur_spsr] <= spsr_wdata;
      if (mode_we)  mode_q           <= mode_in;
      rd_data_q    <= rd_data_d;
      spsr_rdata_q <= spsr_rdata_d;
      mode_err_q   <= !mode_valid(mode_q);
    end
  end

  assign mode       = mode_q;
  assign rd_data    = rd_data_q;
  assign spsr_rdata = spsr_rdata_q;
  assign mode_err   = mode_err_q;

endmodule

// File: doc/banked_regfile.md
BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 Parameter NRD, default 3: number of read ports, legal range 1..4.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, synchronous to clk, active-high.
REQ-005 Port mode_we  input  1  load mode_in into the mode register.
REQ-006 Port mode_in  input  5  new processor mode (CPSR[4:0]).
REQ-007 Port mode  output  5  current mode register.
REQ-008 Port user_bank  input  1  force USR mapping for this cycle's reads and write (LDM/STM with ^).
REQ-009 Port rd_reg  input  NRD*4  logical register field per read port; port i is bits [4i+3:4i].
REQ-010 Port rd_data  output  NRD*DW  registered read data per read port.
REQ-011 Port pc_in  input  DW  value returned for logical R15.
REQ-012 Port wr_en  input  1  write strobe.
REQ-013 Port wr_reg  input  4  logical destination register.
REQ-014 Port wr_data  input  DW  write data.
REQ-015 Port spsr_we  input  1  write the SPSR of the current mode.
REQ-016 Port spsr_wdata  input  DW  SPSR write data.
REQ-017 Port spsr_rdata  output  DW  registered SPSR of the current mode.
REQ-018 Port mode_err  output  1  registered flag: mode register holds an unlisted encoding.

Function
REQ-019 Storage SHALL be 31 physical registers, addresses 0x00-0x1E; R15 is not stored.
REQ-020 Mapping: FIQ R8-R14 -> 0x10-0x16; SVC R13/R14 -> 0x17/0x18; ABT -> 0x19/0x1A; IRQ -> 0x1B/0x1C; UND -> 0x1D/0x1E; all other cases -> {0, reg}.
REQ-021 USR, SYS, unlisted modes, and any access with user_bank=1 SHALL use the {0, reg} mapping.
REQ-022 Read latency SHALL be exactly 1 cycle: rd_data port i at cycle n+1 reflects rd_reg port i and mode at cycle n.
REQ-023 Logical R15 reads SHALL return pc_in sampled at cycle n; writes to R15 SHALL be ignored.
REQ-024 A write SHALL update the mapped physical register at the clock edge when wr_en=1.
REQ-025 Same-cycle write and read of the same physical address SHALL return wr_data (write-through bypass).
REQ-026 A bypass SHALL NOT occur for the same logical but a different physical register (e.g. FIQ write of R8, user_bank read of R8).
REQ-027 When mode_we and wr_en/reads coincide, mapping SHALL use the old mode; the new mode takes effect the next cycle.
REQ-028 SPSR bank: five DW-bit registers (FIQ, SVC, ABT, IRQ, UND); spsr_rdata registered 1 cycle from mode, with bypass on same-cycle spsr_we.
REQ-029 In USR, SYS or unlisted modes, spsr_we SHALL be ignored and spsr_rdata SHALL read 0.
REQ-030 mode_err SHALL be 1 the cycle after the mode register holds an encoding other than USR, FIQ, IRQ, SVC, ABT, UND or SYS.
REQ-031 Simultaneous mode_we and spsr_we SHALL write the SPSR of the old mode.

Reset
REQ-032 On reset: all 31 registers = 0, all SPSRs = 0, mode = SVC (5'b10011), rd_data = 0, spsr_rdata = 0, mode_err = 0.
REQ-033 Reset SHALL dominate wr_en, spsr_we and mode_we in the same cycle; a write or mode change presented with reset is lost.

Structure
REQ-034 Mode encodings (USR, FIQ, IRQ, SVC, ABT, UND, SYS) and bank base addresses SHALL live in the shared pardef definitions.
REQ-035 One combinational sub-module, bank_addr_map (inputs reg, mode, user_bank; output 5-bit address), SHALL be instantiated NRD+1 times.

Verification
REQ-036 Reset, then read R0-R14 in SVC -> all 0 one cycle later; mode=5'b10011.
REQ-037 In USR write R13=0xAAAA0001; switch to IRQ and write R13=0xBBBB0002; read R13 -> 0xBBBB0002; user_bank read -> 0xAAAA0001.
REQ-038 In FIQ write R8=0x12345678 and read R8 in the same cycle -> 0x12345678 next cycle; USR read of R8 -> 0.
REQ-039 Same cycle: mode_we (SVC->ABT) with wr_en R14=0x55 -> SVC R14=0x55 and ABT R14 unchanged; SPSR write in the same cycle lands in SVC.
REQ-040 Read R15 with pc_in=0x8000 -> 0x8000; write R15=0x1 -> no physical register changes.
REQ-041 mode_in=5'b00101 loaded -> mode_err=1, reads use USR mapping, spsr_rdata=0; assert reset mid-write -> all outputs 0, write discarded.
